// File: rtl/result_collector_if.sv
// Bus between the four-operand multiplier, the result collector and the
// product consumer. Groups the Done/Acknowledge handshake, the show-ahead
// read port and the FIFO status outputs.
interface result_collector_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 3
);
    logic                  iDone;
    logic [DATA_WIDTH-1:0] iResult;
    logic                  oAcknoledged;
    logic                  iRead;
    logic                  oValid;
    logic [DATA_WIDTH-1:0] oData;
    logic [ADDR_WIDTH:0]   oCount;
    logic                  oFull;
    logic                  oEmpty;
    logic [15:0]           oTotal;

    // Collector side: consumes the handshake and read request, drives status
    modport slave (
        input  iDone, iResult, iRead,
        output oAcknoledged, oValid, oData, oCount, oFull, oEmpty, oTotal
    );

    // Environment side: multiplier plus consumer
    modport master (
        output iDone, iResult, iRead,
        input  oAcknoledged, oValid, oData, oCount, oFull, oEmpty, oTotal
    );
endinterface

// File: rtl/result_collector.sv
// Result collector: finishes the multiplier's four-phase Done/Acknowledge
// handshake, buffers each product in a DEPTH-entry FIFO and presents the
// head entry on a show-ahead valid/read port. A full FIFO simply withholds
// the acknowledge, which keeps the multiplier parked in Done.
module result_collector #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    result_collector_if.slave    bus
);

    localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic                   ack_q, ack_d;
    logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]    count_q, count_d;
    logic [15:0]            total_q, total_d;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    logic                   full;
    logic                   empty;
    logic                   cap;
    logic                   pop;

    // Status flags come straight from the registered count, so the full
    // check in the FSM always sees the pre-edge occupancy.
    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    // Handshake FSM next-state: capture only from idle with room available;
    // hold acknowledge until the multiplier drops Done.
    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        cap     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.iDone && !full) begin
                    cap     = 1'b1;
                    ack_d   = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (bus.iDone) begin
                    ack_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pop is honoured only when there is something to pop; a read on an
    // empty FIFO leaves pointers and count untouched.
    assign pop = bus.iRead && !empty;

    // FIFO bookkeeping: pointers wrap naturally at DEPTH (power of two);
    // a simultaneous capture and pop leaves the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        total_d  = total_q;
        if (cap) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            total_d  = total_q + 16'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end
        case ({cap, pop})
            2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state: asynchronous reset discards everything and drops the
    // acknowledge immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ack_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            total_q  <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            total_q  <= total_d;
        end
    end

    // Storage array has no reset; entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (cap) begin
            mem[wr_ptr_q] <= bus.iResult;
        end
    end

    assign bus.oAcknoledged = ack_q;
    assign bus.oValid       = !empty;
    assign bus.oData        = mem[rd_ptr_q];
    assign bus.oCount       = count_q;
    assign bus.oFull        = full;
    assign bus.oEmpty       = empty;
    assign bus.oTotal       = total_q;

    // Occupancy stays within 0..DEPTH.
    a_count_range: assert property (@(posedge clk) disable iff (rst)
        count_q <= CNT_FULL);

    // The acknowledge is high exactly while the FSM sits in S_ACK.
    a_ack_state: assert property (@(posedge clk) disable iff (rst)
        ack_q == (state_q == S_ACK));

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: stimulus pushes expected products
// into a scoreboard queue, a negedge monitor pops and compares whenever a
// read is accepted by the DUT.
module tb_result_collector;
    localparam int DW = 64;
    localparam int AW = 3;

    logic clk;
    logic rst;
    int   total_cnt;
    int   bad_cnt;
    logic [DW-1:0] exp_q[$];

    result_collector_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    result_collector #(.DATA_WIDTH(DW), .DEPTH(8), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full handshake for one product; bounded wait for the acknowledge.
    task automatic capture(input logic [DW-1:0] v);
        logic got;
        bus.iDone   = 1'b1;
        bus.iResult = v;
        exp_q.push_back(v);
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            step();
            got = bus.oAcknoledged;
        end
        check("cap_ack", 64'(got), 64'd1);
        bus.iDone = 1'b0;
        step();
        check("cap_release", 64'(bus.oAcknoledged), 64'd0);
    endtask

    task automatic pop_n(input int n);
        bus.iRead = 1'b1;
        repeat (n) step();
        bus.iRead = 1'b0;
    endtask

    // Monitor: a read is accepted at the coming edge when iRead && oValid
    always @(negedge clk) begin
        if (!rst && bus.iRead && bus.oValid) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                bad_cnt++;
                $display("FAIL mon_data: unexpected pop, got %0d expected none", bus.oData);
            end else begin
                check("mon_data", bus.oData, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ackcnt;
        total_cnt   = 0;
        bad_cnt     = 0;
        rst         = 1'b0;
        bus.iDone   = 1'b0;
        bus.iResult = '0;
        bus.iRead   = 1'b0;

        // T1 reset
        #1 rst = 1'b1;
        #1;
        check("rst_ack",   64'(bus.oAcknoledged), 64'd0);
        check("rst_valid", 64'(bus.oValid), 64'd0);
        check("rst_empty", 64'(bus.oEmpty), 64'd1);
        check("rst_full",  64'(bus.oFull), 64'd0);
        check("rst_count", 64'(bus.oCount), 64'd0);
        check("rst_total", 64'(bus.oTotal), 64'd0);
        @(negedge clk) rst = 1'b0;
        step();

        // T2 single capture
        bus.iDone   = 1'b1;
        bus.iResult = 64'd24;
        exp_q.push_back(64'd24);
        step();
        check("t2_ack",   64'(bus.oAcknoledged), 64'd1);
        check("t2_data",  bus.oData, 64'd24);
        check("t2_count", 64'(bus.oCount), 64'd1);
        check("t2_total", 64'(bus.oTotal), 64'd1);
        check("t2_valid", 64'(bus.oValid), 64'd1);
        bus.iDone = 1'b0;
        step();
        check("t2_release", 64'(bus.oAcknoledged), 64'd0);
        check("t2_hold",    bus.oData, 64'd24);
        pop_n(1);
        check("t2_empty", 64'(bus.oEmpty), 64'd1);

        // T3 fill and back-pressure
        for (int i = 1; i <= 8; i++) capture(64'(i));
        check("t3_full",  64'(bus.oFull), 64'd1);
        check("t3_count", 64'(bus.oCount), 64'd8);
        bus.iDone   = 1'b1;
        bus.iResult = 64'd9;
        exp_q.push_back(64'd9);
        ackcnt = 0;
        repeat (20) begin
            step();
            if (bus.oAcknoledged) ackcnt++;
        end
        check("t3_stall_acks", 64'(ackcnt), 64'd0);
        check("t3_stall_count", 64'(bus.oCount), 64'd8);
        bus.iRead = 1'b1;
        step();
        bus.iRead = 1'b0;
        check("t3_pop_ack",   64'(bus.oAcknoledged), 64'd0);
        check("t3_pop_count", 64'(bus.oCount), 64'd7);
        step();
        check("t3_late_ack",   64'(bus.oAcknoledged), 64'd1);
        check("t3_late_count", 64'(bus.oCount), 64'd8);
        bus.iDone = 1'b0;
        step();
        check("t3_release", 64'(bus.oAcknoledged), 64'd0);
        pop_n(8);
        check("t3_drained", 64'(bus.oEmpty), 64'd1);

        // T4 concurrent capture and pop at count 3
        capture(64'd31);
        capture(64'd32);
        capture(64'd33);
        check("t4_count0", 64'(bus.oCount), 64'd3);
        bus.iDone   = 1'b1;
        bus.iResult = 64'd34;
        exp_q.push_back(64'd34);
        bus.iRead   = 1'b1;
        step();
        bus.iRead = 1'b0;
        check("t4_count", 64'(bus.oCount), 64'd3);
        check("t4_ack",   64'(bus.oAcknoledged), 64'd1);
        check("t4_head",  bus.oData, 64'd32);
        bus.iDone = 1'b0;
        step();
        pop_n(3);
        check("t4_empty", 64'(bus.oEmpty), 64'd1);

        // T5 wrap-around and reads on empty
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        step();
        check("t5_total0", 64'(bus.oTotal), 64'd0);
        for (int i = 0; i < 20; i++) begin
            capture(64'(100 + i));
            pop_n(1);
        end
        check("t5_total", 64'(bus.oTotal), 64'd20);
        check("t5_empty", 64'(bus.oEmpty), 64'd1);
        bus.iRead = 1'b1;
        step();
        step();
        bus.iRead = 1'b0;
        check("t5_rd_empty_count", 64'(bus.oCount), 64'd0);
        check("t5_rd_empty_valid", 64'(bus.oValid), 64'd0);
        capture(64'd200);
        check("t5_after_data",  bus.oData, 64'd200);
        check("t5_after_count", 64'(bus.oCount), 64'd1);
        pop_n(1);

        // T6 reset in the middle of a handshake
        bus.iDone   = 1'b1;
        bus.iResult = 64'd77;
        exp_q.push_back(64'd77);
        step();
        check("t6_ack_before", 64'(bus.oAcknoledged), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_ack",   64'(bus.oAcknoledged), 64'd0);
        check("t6_count", 64'(bus.oCount), 64'd0);
        check("t6_empty", 64'(bus.oEmpty), 64'd1);
        exp_q.delete();
        bus.iDone = 1'b0;
        @(negedge clk) rst = 1'b0;
        step();
        check("t6_idle_ack", 64'(bus.oAcknoledged), 64'd0);

        check("scoreboard_left", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
